// File: rtl/shader_program_loader.sv
// Shader program loader: collects a NUM_INSTR-long instruction stream into a
// shadow buffer and streams it into shader memory only on a frame boundary,
// so a reprogram never tears mid-frame.
// Optional build macro SHADER_LOADER_CHECKSUM_EN: FILL expects one extra XOR
// checksum byte after the instructions and adds the sticky checksum_err_o port.
module shader_program_loader #(
  parameter int unsigned NUM_INSTR = 16,
  parameter int unsigned INSTR_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [INSTR_W-1:0] byte_i,
  input  logic               byte_valid_i,
  output logic               byte_ready_o,
  input  logic               frame_start_i,
  output logic [INSTR_W-1:0] memory_instr_o,
  output logic               memory_shift_o,
  output logic               memory_load_o,
  output logic               pending_o,
  output logic               busy_o,
  output logic               commit_done_o,
  output logic               overflow_o
`ifdef SHADER_LOADER_CHECKSUM_EN
  ,
  output logic               checksum_err_o
`endif
);

  localparam int unsigned     PtrW    = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NUM_INSTR - 1);

  typedef enum logic [1:0] {StIdle, StFill, StPending, StCommit} state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [INSTR_W-1:0] mem_q [NUM_INSTR];
  logic               accept;
  logic               mem_we;
  logic               load_q, load_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;

`ifdef SHADER_LOADER_CHECKSUM_EN
  // chk_phase_q: all instructions stored, next accepted byte is the checksum
  logic               chk_phase_q, chk_phase_d;
  logic [INSTR_W-1:0] xor_q, xor_d;
  logic               chk_err_q, chk_err_d;
`endif

  // State register and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      load_q   <= 1'b0;
      instr_q  <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef SHADER_LOADER_CHECKSUM_EN
      chk_phase_q <= 1'b0;
      xor_q       <= '0;
      chk_err_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      load_q   <= load_d;
      instr_q  <= instr_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
`ifdef SHADER_LOADER_CHECKSUM_EN
      chk_phase_q <= chk_phase_d;
      xor_q       <= xor_d;
      chk_err_q   <= chk_err_d;
`endif
    end
  end

  // Shadow buffer write; contents are don't-care after reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= byte_i;
    end
  end

  // Next-state logic and pointer updates
  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    accept   = byte_valid_i && byte_ready_o;
    mem_we   = accept;
`ifdef SHADER_LOADER_CHECKSUM_EN
    chk_phase_d = chk_phase_q;
    xor_d       = xor_q;
    chk_err_d   = start_i ? 1'b0 : chk_err_q;
    mem_we      = accept && !chk_phase_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d  = StFill;
          wr_ptr_d = '0;
`ifdef SHADER_LOADER_CHECKSUM_EN
          chk_phase_d = 1'b0;
          xor_d       = '0;
`endif
        end
      end
      StFill: begin
        if (start_i) begin
          wr_ptr_d = '0;
`ifdef SHADER_LOADER_CHECKSUM_EN
          chk_phase_d = 1'b0;
          xor_d       = '0;
`endif
        end else if (accept) begin
`ifdef SHADER_LOADER_CHECKSUM_EN
          if (chk_phase_q) begin
            chk_phase_d = 1'b0;
            if (byte_i == xor_q) begin
              state_d = StPending;
            end else begin
              state_d   = StIdle;
              chk_err_d = 1'b1;
            end
          end else begin
            xor_d = xor_q ^ byte_i;
            if (wr_ptr_q == LastIdx) begin
              chk_phase_d = 1'b1;
            end else begin
              wr_ptr_d = wr_ptr_q + 1'b1;
            end
          end
`else
          if (wr_ptr_q == LastIdx) begin
            state_d = StPending;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
`endif
        end
      end
      StPending: begin
        // A restart takes priority over a frame boundary
        if (start_i) begin
          state_d  = StFill;
          wr_ptr_d = '0;
`ifdef SHADER_LOADER_CHECKSUM_EN
          chk_phase_d = 1'b0;
          xor_d       = '0;
`endif
        end else if (frame_start_i) begin
          state_d  = StCommit;
          rd_ptr_d = '0;
        end
      end
      StCommit: begin
        if (rd_ptr_q == LastIdx) begin
          state_d = StIdle;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output decode: ready handshake and next values of registered strobes
  always_comb begin
    byte_ready_o = (state_q == StFill) && !start_i;
    load_d       = (state_d == StCommit);
    instr_d      = load_d ? mem_q[rd_ptr_d] : '0;
    done_d       = (state_q == StCommit) && (state_d == StIdle);
    ovf_d        = start_i ? 1'b0 : ovf_q;
    if (byte_valid_i && !byte_ready_o) begin
      ovf_d = 1'b1;
    end
  end

  assign memory_load_o  = load_q;
  assign memory_shift_o = load_q;
  assign memory_instr_o = instr_q;
  assign commit_done_o  = done_q;
  assign overflow_o     = ovf_q;
  assign pending_o      = (state_q == StPending);
  assign busy_o         = (state_q != StIdle);
`ifdef SHADER_LOADER_CHECKSUM_EN
  assign checksum_err_o = chk_err_q;
`endif

endmodule

// File: tb/tb_shader_program_loader.sv
// Directed-sequence bench for shader_program_loader with randomized programs.
// Reference model: a queue holding the bytes accepted since the last start;
// a commit must replay exactly that queue, one strobe per cycle.
module tb_shader_program_loader;

  localparam int unsigned NumInstr = 16;
  localparam int unsigned InstrW   = 8;
`ifdef SHADER_LOADER_CHECKSUM_EN
  localparam int NumBytes = NumInstr + 1;
`else
  localparam int NumBytes = NumInstr;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              start_i;
  logic [InstrW-1:0] byte_i;
  logic              byte_valid_i;
  logic              byte_ready_o;
  logic              frame_start_i;
  logic [InstrW-1:0] memory_instr_o;
  logic              memory_shift_o;
  logic              memory_load_o;
  logic              pending_o;
  logic              busy_o;
  logic              commit_done_o;
  logic              overflow_o;
`ifdef SHADER_LOADER_CHECKSUM_EN
  logic              checksum_err_o;
`endif

  shader_program_loader #(
    .NUM_INSTR(NumInstr),
    .INSTR_W  (InstrW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .byte_i        (byte_i),
    .byte_valid_i  (byte_valid_i),
    .byte_ready_o  (byte_ready_o),
    .frame_start_i (frame_start_i),
    .memory_instr_o(memory_instr_o),
    .memory_shift_o(memory_shift_o),
    .memory_load_o (memory_load_o),
    .pending_o     (pending_o),
    .busy_o        (busy_o),
    .commit_done_o (commit_done_o),
    .overflow_o    (overflow_o)
`ifdef SHADER_LOADER_CHECKSUM_EN
    ,
    .checksum_err_o(checksum_err_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  logic [InstrW-1:0] prog [NumInstr];
  logic [InstrW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic new_prog();
    for (int i = 0; i < NumInstr; i++) prog[i] = InstrW'($urandom_range(0, 255));
  endtask

  task automatic do_start();
    start_i      = 1'b1;
    byte_valid_i = 1'b0;
    step();
    start_i = 1'b0;
    exp_q.delete();
    check("start_busy", busy_o, 1);
    check("start_clears_ovf", overflow_o, 0);
    check("start_not_pending", pending_o, 0);
  endtask

  // Offer the program (plus checksum byte when enabled) with valid held high.
  // frame_start_i is pulsed together with byte indices fs_a / fs_b.
  task automatic fill_prog(input int fs_a, input int fs_b, input bit bad_chk);
    logic [InstrW-1:0] x;
    x = '0;
    for (int i = 0; i < NumBytes; i++) begin
      if (i < NumInstr) begin
        byte_i = prog[i];
        x      = x ^ prog[i];
      end else begin
        byte_i = bad_chk ? ~x : x;
      end
      byte_valid_i  = 1'b1;
      frame_start_i = (i == fs_a) || (i == fs_b);
      #1 check("fill_ready", byte_ready_o, 1);
      step();
      if (i < NumInstr) exp_q.push_back(prog[i]);
      check("fill_no_strobe", memory_load_o, 0);
      check("fill_pending", pending_o, ((i == NumBytes - 1) && !bad_chk) ? 1 : 0);
    end
    byte_valid_i  = 1'b0;
    frame_start_i = 1'b0;
    if (bad_chk) exp_q.delete();
  endtask

  task automatic no_strobe(input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check("no_strobe", memory_load_o, 0);
    end
  endtask

  task automatic commit_expect();
    frame_start_i = 1'b1;
    check("pre_commit_no_strobe", memory_load_o, 0);
    step();
    frame_start_i = 1'b0;
    for (int i = 0; i < NumInstr; i++) begin
      check("commit_load", memory_load_o, 1);
      check("commit_shift", memory_shift_o, 1);
      check("commit_instr", memory_instr_o, (i < exp_q.size()) ? 32'(exp_q[i]) : 32'hx);
      check("commit_done_early", commit_done_o, 0);
      step();
    end
    check("post_load", memory_load_o, 0);
    check("post_shift", memory_shift_o, 0);
    check("post_instr", memory_instr_o, 0);
    check("commit_done", commit_done_o, 1);
    check("post_busy", busy_o, 0);
    step();
    check("commit_done_pulse", commit_done_o, 0);
  endtask

  initial begin
    rst_i         = 1'b1;
    start_i       = 1'b0;
    byte_i        = '0;
    byte_valid_i  = 1'b0;
    frame_start_i = 1'b0;
    #12;
    check("rst_busy", busy_o, 0);
    check("rst_pending", pending_o, 0);
    check("rst_load", memory_load_o, 0);
    check("rst_shift", memory_shift_o, 0);
    check("rst_instr", memory_instr_o, 0);
    check("rst_done", commit_done_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_ready", byte_ready_o, 0);
`ifdef SHADER_LOADER_CHECKSUM_EN
    check("rst_chk_err", checksum_err_o, 0);
`endif
    @(negedge clk_i);
    rst_i = 1'b0;
    step();

    // Basic program 0x00..0x0F
    do_start();
    for (int i = 0; i < NumInstr; i++) prog[i] = InstrW'(i);
    fill_prog(-1, -1, 1'b0);
    commit_expect();

    // Partial fill, restart, full program 0xA0..0xAF
    do_start();
    new_prog();
    for (int i = 0; i < 8; i++) begin
      byte_i       = prog[i];
      byte_valid_i = 1'b1;
      step();
    end
    byte_valid_i = 1'b0;
    do_start();
    for (int i = 0; i < NumInstr; i++) prog[i] = InstrW'(8'hA0 + i);
    fill_prog(-1, -1, 1'b0);
    commit_expect();

    // Overflow in IDLE and PENDING; buffer must stay intact
    byte_i       = 8'h55;
    byte_valid_i = 1'b1;
    #1 check("idle_ready", byte_ready_o, 0);
    step();
    byte_valid_i = 1'b0;
    check("idle_ovf", overflow_o, 1);
    step();
    check("idle_ovf_sticky", overflow_o, 1);
    do_start();
    new_prog();
    fill_prog(-1, -1, 1'b0);
    byte_i       = 8'hC3;
    byte_valid_i = 1'b1;
    #1 check("pend_ready", byte_ready_o, 0);
    step();
    byte_valid_i = 1'b0;
    check("pend_ovf", overflow_o, 1);
    check("pend_still", pending_o, 1);
    commit_expect();
    check("ovf_after_commit", overflow_o, 1);
    do_start();

    // frame_start during FILL and with the last accept: no commit until next pulse
    new_prog();
    fill_prog(5, NumBytes - 1, 1'b0);
    no_strobe(3);
    check("late_pending", pending_o, 1);
    commit_expect();

    // start and frame_start together in PENDING: restart wins
    do_start();
    new_prog();
    fill_prog(-1, -1, 1'b0);
    start_i       = 1'b1;
    frame_start_i = 1'b1;
    step();
    start_i       = 1'b0;
    frame_start_i = 1'b0;
    exp_q.delete();
    check("restart_pending", pending_o, 0);
    check("restart_busy", busy_o, 1);
    check("restart_no_strobe", memory_load_o, 0);
    no_strobe(2);
    new_prog();
    fill_prog(-1, -1, 1'b0);
    commit_expect();

    // Reset on the 5th commit strobe
    do_start();
    new_prog();
    fill_prog(-1, -1, 1'b0);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("pre_rst_instr", memory_instr_o, exp_q[i]);
      step();
    end
    check("fifth_strobe", memory_load_o, 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_load", memory_load_o, 0);
    check("mid_rst_shift", memory_shift_o, 0);
    check("mid_rst_instr", memory_instr_o, 0);
    check("mid_rst_pending", pending_o, 0);
    check("mid_rst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    no_strobe(2);
    check("post_rst_busy", busy_o, 0);

`ifdef SHADER_LOADER_CHECKSUM_EN
    // Wrong checksum: error flag, back to IDLE, frame pulse commits nothing
    do_start();
    new_prog();
    fill_prog(-1, -1, 1'b1);
    check("chk_err_set", checksum_err_o, 1);
    check("chk_err_idle", busy_o, 0);
    frame_start_i = 1'b1;
    step();
    frame_start_i = 1'b0;
    check("chk_err_no_strobe", memory_load_o, 0);
    no_strobe(2);
    check("chk_err_sticky", checksum_err_o, 1);
    do_start();
    check("chk_err_cleared", checksum_err_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shader_program_loader.md
Name: shader_program_loader

Overview:
- Upstream of the shader memory. Takes a byte stream of shader instructions from the SPI command path and holds it in a NUM_INSTR-deep shadow buffer.
- Once the program is complete, streams it into the shader memory (memory_instr/shift/load) only on a frame boundary, so a reprogram never tears mid-frame.
- Gives glitch-free program swaps while the VGA timing and shader execution run continuously.

Parameters:
- NUM_INSTR, 16, program length in instructions; shadow buffer depth and commit length.
- INSTR_W, 8, instruction width in bits.

Ports:
- clk_i  in  1  system clock (50.350 MHz)
- rst_i  in  1  asynchronous reset, active-high
- start_i  in  1  pulse: begin receiving a new program
- byte_i  in  INSTR_W  instruction byte from SPI path
- byte_valid_i  in  1  byte_i valid this cycle
- byte_ready_o  out  1  loader accepts byte this cycle
- frame_start_i  in  1  one-cycle pulse at start of frame (next_frame)
- memory_instr_o  out  INSTR_W  instruction to shader memory
- memory_shift_o  out  1  shader memory shift strobe
- memory_load_o  out  1  shader memory load strobe
- pending_o  out  1  complete program waiting for frame boundary
- busy_o  out  1  state is FILL, PENDING or COMMIT
- commit_done_o  out  1  one-cycle pulse after last instruction committed
- overflow_o  out  1  sticky: byte offered while not in FILL

Behaviour:
- Reset (async, rst_i=1): state IDLE, wr_ptr=0, rd_ptr=0. All outputs 0 (memory_instr_o=0). Buffer contents undefined. Reset mid-COMMIT leaves shader memory partially loaded; no recovery is attempted.
- States: IDLE, FILL, PENDING, COMMIT.
- IDLE: byte_ready_o=0. start_i=1 -> FILL, wr_ptr=0.
- FILL: byte_ready_o = !start_i (combinational).
  - On byte_valid_i & byte_ready_o: buf[wr_ptr]=byte_i, wr_ptr++.
  - Accepting byte NUM_INSTR-1 -> PENDING.
  - start_i=1 restarts: wr_ptr=0, stay FILL; a byte offered in the same cycle is dropped (ready low).
  - frame_start_i is ignored.
- PENDING: pending_o=1, byte_ready_o=0.
  - frame_start_i=1 -> COMMIT, rd_ptr=0.
  - start_i=1 -> FILL, wr_ptr=0; the pending program is discarded.
  - If start_i and frame_start_i arrive together, start_i wins.
  - A frame_start_i in the same cycle as the last byte accept does not commit; the commit waits for the next pulse.
- COMMIT: exactly NUM_INSTR cycles.
  - Each cycle: memory_load_o=1, memory_shift_o=1, memory_instr_o=buf[rd_ptr], rd_ptr++. Order is buf[0] first.
  - Outputs are registered: first strobe appears the cycle after the frame_start_i sample.
  - start_i and frame_start_i are ignored (not queued).
  - After the last strobe -> IDLE, with commit_done_o=1 for one cycle in that IDLE cycle.
- Outside COMMIT: memory_load_o=memory_shift_o=0, memory_instr_o holds 0.
- overflow_o: set when byte_valid_i=1 and byte_ready_o=0 in any state; cleared by start_i (set wins if both occur in the same cycle).
- Pointers are $clog2(NUM_INSTR) bits. wr_ptr never wraps: saturation is covered by the FILL->PENDING transition.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: SHADER_LOADER_CHECKSUM_EN.
- With the macro defined:
  - FILL expects NUM_INSTR+1 bytes; the last byte is the XOR of all instruction bytes. The checksum byte is not stored.
  - Match -> PENDING.
  - Mismatch -> IDLE, and extra output port checksum_err_o (1 bit, sticky, cleared by start_i, reset 0) is set.
- Without the macro: no checksum byte, no checksum_err_o port.

Test Plan:
- Reset, start_i, 16 bytes 0x00..0x0F with valid held -> pending_o=1 after 16th accept. frame_start_i -> 16 consecutive load/shift strobes carrying 0x00..0x0F in order. commit_done_o pulses on the following cycle; busy_o=0.
- Fill 8 bytes, pulse start_i, fill 16 bytes 0xA0..0xAF -> commit carries only 0xA0..0xAF.
- Byte offered in IDLE and in PENDING -> overflow_o=1 and stays 1; next start_i clears it; buffer unchanged.
- frame_start_i during FILL and in the same cycle as the 16th byte -> no strobes. Commit occurs only on the next frame_start_i.
- Assert rst_i on the 5th COMMIT strobe -> strobes and memory_instr_o drop to 0 immediately; state IDLE; pending_o=0.
- (SHADER_LOADER_CHECKSUM_EN) 16 bytes plus correct XOR -> commit as normal. 16 bytes plus wrong XOR -> checksum_err_o=1, IDLE, no strobes on the next frame_start_i.
